// File: rtl/trig_pkg.sv
// Shared types and default sizes for the trigger-capture block.
package trig_pkg;
  localparam int D_WIDTH_DEF = 8;
  localparam int A_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_e;
endpackage

// File: rtl/capture_mem.sv
// Capture buffer: DEPTH x D_WIDTH, synchronous write, asynchronous read, no reset.
module capture_mem
  import trig_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [A_WIDTH-1:0] i_waddr,
  input  logic [D_WIDTH-1:0] i_wdata,
  input  logic [A_WIDTH-1:0] i_raddr,
  output logic [D_WIDTH-1:0] o_rdata
);
  localparam int DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] r_mem [DEPTH];

  // Sample storage write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/trig_capture.sv
// Triggered capture of a sample stream: arm, wait for a rising crossing of
// trig_level, capture DEPTH samples starting at the trigger, then read them out.
module trig_capture
  import trig_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] din,
  input  logic               din_vld,
  input  logic               arm,
  input  logic [D_WIDTH-1:0] trig_level,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic               busy,
  output logic               triggered
);
  localparam logic [A_WIDTH-1:0] A_LAST = {A_WIDTH{1'b1}};

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  state_e             r_state;
  logic [A_WIDTH-1:0] r_wr_ptr;
  logic [A_WIDTH-1:0] r_rd_ptr;
  logic [D_WIDTH-1:0] r_prev;
  logic               r_prev_vld;
  logic               w_cross;
  logic               w_trig;
  logic               w_we;
  logic               w_dout_vld;
  logic [D_WIDTH-1:0] w_rd_data;

  // Reset asserts immediately, releases two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Rising crossing needs a valid previous sample below the threshold.
  assign w_cross    = din_vld & r_prev_vld & (r_prev < trig_level) & (din >= trig_level);
  assign w_trig     = (r_state == ST_ARMED) & w_cross;
  assign w_we       = w_trig | ((r_state == ST_CAPTURE) & din_vld);
  assign w_dout_vld = (r_state == ST_READOUT);

  // Control FSM with write/read pointers and previous-sample tracking.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state    <= ST_ARMED;
            r_prev_vld <= 1'b0;
            r_wr_ptr   <= '0;
          end
        end
        ST_ARMED: begin
          if (din_vld) begin
            if (w_cross) begin
              // Trigger sample lands at address 0; next write goes to 1.
              r_state  <= ST_CAPTURE;
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end else begin
              r_prev     <= din;
              r_prev_vld <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (din_vld) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == A_LAST) begin
              r_state <= ST_READOUT;
            end
          end
        end
        ST_READOUT: begin
          if (dout_rdy) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_rd_ptr == A_LAST) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  capture_mem #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign dout_vld  = w_dout_vld;
  assign dout      = w_dout_vld ? w_rd_data : '0;
  assign busy      = (r_state != ST_IDLE);
  assign triggered = w_trig;
endmodule

// File: tb/tb_trig_capture.sv
// Scoreboard bench for trig_capture: stimulus pushes expected readout samples,
// a negedge monitor pops and compares them as the DUT presents data.
module tb_trig_capture;
  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_vld;
  logic       arm;
  logic [7:0] trig_level;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic       busy;
  logic       triggered;

  int         err_cnt;
  int         chk_cnt;
  int         xfer_cnt;
  bit         mon_en;
  logic [7:0] exp_q[$];
  int         stim_q[$];
  logic [7:0] sine_tab [16];

  trig_capture #(
    .D_WIDTH (8),
    .A_WIDTH (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_vld    (din_vld),
    .arm        (arm),
    .trig_level (trig_level),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .busy       (busy),
    .triggered  (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL unexpected_out: got dout_vld=1 dout=%0d expected no output", dout);
        end else begin
          check("dout", int'(dout), int'(exp_q[0]));
          if (dout_rdy) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end else begin
        check("dout_zero_when_invalid", int'(dout), 0);
      end
    end
  end

  task automatic push_ramp_stim(input int start, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back((start + 4 * i) & 255);
  endtask

  task automatic push_ramp_exp(input int start);
    for (int k = 0; k < 64; k++) exp_q.push_back(8'((start + 4 * k) & 255));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Arm, stream stim_q, and run until readout starts (or abort_after writes).
  task automatic drive_capture(input bit toggle, input bit arm_noise, input int abort_after,
                               input int budget, output int trig_cnt, output int trig_val,
                               output int cap_cycles);
    int  it;
    int  writes;
    int  trig_idx;
    bit  done;
    it = 0; writes = 0; trig_idx = 0; done = 1'b0;
    trig_cnt = 0; trig_val = -1; cap_cycles = -1;
    while (!done && it < budget) begin
      @(posedge clk);
      #1;
      arm = (it == 0) || (arm_noise && writes > 0 && (it % 5) == 0);
      if (it == 0) begin
        din_vld = 1'b0;
      end else if (toggle && (it % 2) == 0) begin
        din_vld = 1'b0;
        din     = 8'hEE;
      end else begin
        din_vld = 1'b1;
        din     = (stim_q.size() > 0) ? 8'(stim_q.pop_front()) : 8'd0;
      end
      @(negedge clk);
      if (triggered) begin
        trig_cnt++;
        trig_val = din;
        trig_idx = it;
        writes   = 1;
      end else if (writes > 0 && din_vld && !dout_vld) begin
        writes++;
      end
      if (dout_vld) begin
        cap_cycles = it - trig_idx;
        done = 1'b1;
      end
      if (abort_after > 0 && writes == abort_after) done = 1'b1;
      it++;
    end
    arm = 1'b0;
    if (!done) check("capture_timeout", 0, 1);
    if (abort_after == 0) din_vld = 1'b0;
  endtask

  // Drain the readout, optionally with a 30% ready and stray arm pulses.
  task automatic drain(input bit rnd, input bit arm_noise, input string tag);
    int  start;
    int  n;
    bit  ended;
    start = xfer_cnt; n = 0; ended = 1'b0;
    while (!ended && n < 2000) begin
      @(posedge clk);
      #1;
      dout_rdy = rnd ? ($urandom_range(99) < 30) : 1'b1;
      arm      = arm_noise && ($urandom_range(3) == 0);
      @(negedge clk);
      if (!dout_vld) ended = 1'b1;
      n++;
    end
    arm      = 1'b0;
    dout_rdy = 1'b0;
    if (!ended) check({tag, "_readout_timeout"}, 0, 1);
    check({tag, "_xfer_count"}, xfer_cnt - start, 64);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int tc, tv, cc, tcount;
    err_cnt = 0; chk_cnt = 0; xfer_cnt = 0; mon_en = 1'b0;
    rst = 1'b1; din = 8'd0; din_vld = 1'b0; arm = 1'b0;
    trig_level = 8'd100; dout_rdy = 1'b0;
    sine_tab = '{8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177,
                 8'd128, 8'd79,  8'd38,  8'd11,  8'd0,   8'd11,  8'd38,  8'd79};
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_dout_vld", int'(dout_vld), 0);
    check("rst_triggered", int'(triggered), 0);
    check("rst_dout", int'(dout), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;

    // Ramp, din_vld every cycle, ready always high.
    stim_q.delete(); push_ramp_stim(0, 160); push_ramp_exp(100);
    dout_rdy = 1'b1;
    drive_capture(1'b0, 1'b0, 0, 300, tc, tv, cc);
    check("t1_trig_count", tc, 1);
    check("t1_trig_value", tv, 100);
    check("t1_capture_cycles", cc, 64);
    drain(1'b0, 1'b0, "t1");

    // Same ramp with din_vld toggling, arm pulses during capture and readout.
    stim_q.delete(); push_ramp_stim(0, 160); push_ramp_exp(100);
    dout_rdy = 1'b1;
    drive_capture(1'b1, 1'b1, 0, 500, tc, tv, cc);
    check("t2_trig_count", tc, 1);
    check("t2_trig_value", tv, 100);
    check("t2_capture_cycles", cc, 127);
    drain(1'b0, 1'b1, "t2");

    // First sample above threshold must not trigger; random-ready readout.
    stim_q.delete();
    stim_q.push_back(150); stim_q.push_back(160); stim_q.push_back(50);
    push_ramp_stim(120, 100); push_ramp_exp(120);
    dout_rdy = 1'b0;
    drive_capture(1'b0, 1'b0, 0, 300, tc, tv, cc);
    check("t3_trig_count", tc, 1);
    check("t3_trig_value", tv, 120);
    drain(1'b1, 1'b1, "t3");

    // Reset after the 20th capture write, then a full fresh capture.
    stim_q.delete(); push_ramp_stim(0, 160);
    drive_capture(1'b0, 1'b0, 20, 300, tc, tv, cc);
    check("t4_trig_value", tv, 100);
    @(posedge clk);
    #1 rst = 1'b0; din_vld = 1'b0;
    #1;
    check("t4_rst_busy", int'(busy), 0);
    check("t4_rst_dout_vld", int'(dout_vld), 0);
    check("t4_rst_triggered", int'(triggered), 0);
    check("t4_rst_dout", int'(dout), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_idle_after_release", int'(busy), 0);
    stim_q.delete(); push_ramp_stim(0, 160); push_ramp_exp(100);
    dout_rdy = 1'b1;
    drive_capture(1'b0, 1'b0, 0, 300, tc, tv, cc);
    check("t4_rearm_trig_value", tv, 100);
    check("t4_rearm_capture_cycles", cc, 64);
    drain(1'b0, 1'b0, "t4");

    // trig_level 0 never triggers: sine input for 1000 cycles.
    trig_level = 8'd0;
    tcount = 0;
    @(posedge clk);
    #1 arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      din_vld = 1'b1;
      din     = sine_tab[i % 16];
      @(negedge clk);
      if (triggered) tcount++;
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    check("t5_trig_count", tcount, 0);
    check("t5_busy", int'(busy), 1);
    check("t5_dout_vld", int'(dout_vld), 0);
    do_reset();
    check("t5_busy_after_reset", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
